// File: rtl/clock_run_controller.sv
// -----------------------------------------------------------------------------
// clock_run_controller
//
// Sequences reset release for the Arty RV32I system and gates core execution.
// After RESET and a filtered PLL lock, peripheral reset is released first and
// then core reset. Once ACTIVE, a registered clock enable (ce) is produced for
// the core in HALT, RUN, SLOW (power-of-two prescaled) or single-STEP fashion.
//
// Ports:
//   CLK           system clock
//   RESET         asynchronous, active-high reset
//   pll_locked    PLL lock indication, synchronous to CLK
//   mode          00 HALT, 01 RUN, 10 SLOW, 11 HALT
//   div_sel       SLOW mode: ce period = 2**div_sel cycles
//   step_req      asynchronous step button (level)
//   halt_req      core halt request, honoured only in a cycle with ce=1
//   ce            core clock enable (registered)
//   periph_resetn peripheral reset, active-low (registered)
//   core_resetn   core reset, active-low (registered)
//   halted        sticky halt flag
//   state         00 WAIT_LOCK, 01 PERIPH_RST, 10 CORE_RST, 11 ACTIVE
//   ce_count      ce pulses since core reset release (wraps)
// -----------------------------------------------------------------------------
module clock_run_controller #(
    parameter int LOCK_FILTER  = 4,
    parameter int PERIPH_DELAY = 16,
    parameter int CORE_DELAY   = 16,
    parameter int DIV_W        = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             pll_locked,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             step_req,
    input  logic             halt_req,
    output logic             ce,
    output logic             periph_resetn,
    output logic             core_resetn,
    output logic             halted,
    output logic [1:0]       state,
    output logic [31:0]      ce_count
);

    // Prescaler must hold 2**div_sel - 1 for the largest div_sel.
    localparam int PW   = (1 << DIV_W) - 1;
    localparam int LW   = $clog2(LOCK_FILTER + 1);
    localparam int DMAX = (PERIPH_DELAY > CORE_DELAY) ? PERIPH_DELAY : CORE_DELAY;
    localparam int DW   = $clog2(DMAX + 1);

    localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_FILTER - 1);
    localparam logic [DW-1:0] PERIPH_LAST = DW'(PERIPH_DELAY - 1);
    localparam logic [DW-1:0] CORE_LAST   = DW'(CORE_DELAY - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'b00,
        PERIPH_RST = 2'b01,
        CORE_RST   = 2'b10,
        ACTIVE     = 2'b11
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;

    logic [LW-1:0]   lock_cnt;
    logic [DW-1:0]   dly_cnt;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_nxt;
    logic [PW-1:0]   presc_mask;

    logic            step_s1;
    logic            step_s2;
    logic            step_prev;
    logic            step_pulse;

    logic [1:0]      mode_q;
    logic [DIV_W-1:0] div_q;
    logic            mode_chg;
    logic            div_chg;

    logic            halt_mode;
    logic            halt_set;
    logic            eff_halt;
    logic            stay_active;

    logic            ce_nxt;
    logic            periph_nxt;
    logic            core_nxt;
    logic            halted_nxt;

    assign state = cur_state;

    // ------------------------------------------------------------------
    // Step button: two-flop synchronizer plus a previous-value flop so a
    // held button yields exactly one rising-edge pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_s1   <= step_req;
            step_s2   <= step_s1;
            step_prev <= step_s2;
        end
    end

    assign step_pulse = step_s2 & ~step_prev;

    // Previous mode / divider, used to detect user changes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_q <= 2'b00;
            div_q  <= '0;
        end else begin
            mode_q <= mode;
            div_q  <= div_sel;
        end
    end

    assign mode_chg = (mode != mode_q);
    assign div_chg  = (div_sel != div_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) cur_state <= WAIT_LOCK;
        else       cur_state <= nxt_state;
    end

    // ------------------------------------------------------------------
    // FSM: next state. Any lock loss outside WAIT_LOCK restarts the whole
    // sequence.
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            WAIT_LOCK: begin
                if (pll_locked && (lock_cnt == LOCK_LAST)) nxt_state = PERIPH_RST;
            end
            PERIPH_RST: begin
                if (!pll_locked)                 nxt_state = WAIT_LOCK;
                else if (dly_cnt == PERIPH_LAST) nxt_state = CORE_RST;
            end
            CORE_RST: begin
                if (!pll_locked)               nxt_state = WAIT_LOCK;
                else if (dly_cnt == CORE_LAST) nxt_state = ACTIVE;
            end
            ACTIVE: begin
                if (!pll_locked) nxt_state = WAIT_LOCK;
            end
            default: nxt_state = WAIT_LOCK;
        endcase
    end

    // Lock filter and reset-delay counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lock_cnt <= '0;
            dly_cnt  <= '0;
        end else begin
            // Counts consecutive locked cycles; any 0 or leaving WAIT_LOCK clears.
            if ((cur_state == WAIT_LOCK) && pll_locked && (nxt_state == WAIT_LOCK))
                lock_cnt <= lock_cnt + 1'b1;
            else
                lock_cnt <= '0;

            // Restarts on every state change so each delay phase begins at 0.
            if (nxt_state != cur_state)
                dly_cnt <= '0;
            else if ((cur_state == PERIPH_RST) || (cur_state == CORE_RST))
                dly_cnt <= dly_cnt + 1'b1;
            else
                dly_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the registered outputs)
    // ------------------------------------------------------------------
    assign presc_mask  = ~({PW{1'b1}} << div_sel);
    assign halt_mode   = (mode == 2'b00) || (mode == 2'b11);
    assign halt_set    = ce & halt_req;
    // A halt request taken this cycle already suppresses the next ce, so
    // the instruction count stops exactly at the halting instruction.
    assign eff_halt    = halt_mode || halted || halt_set;
    assign stay_active = (cur_state == ACTIVE) && (nxt_state == ACTIVE);

    always_comb begin
        ce_nxt     = 1'b0;
        presc_nxt  = '0;
        halted_nxt = 1'b0;
        periph_nxt = (nxt_state == CORE_RST) || (nxt_state == ACTIVE);
        core_nxt   = (nxt_state == ACTIVE);

        if (stay_active) begin
            // Mode change clears the flag and wins over a simultaneous set.
            halted_nxt = (halted || halt_set) && !mode_chg;

            if (eff_halt) begin
                ce_nxt = step_pulse;
            end else if (mode == 2'b01) begin
                ce_nxt = 1'b1;
            end else begin
                // SLOW: a divider of 1 is plain RUN, including on the change
                // cycle; otherwise any change restarts a full period.
                if (presc_mask == '0) begin
                    ce_nxt = 1'b1;
                end else if (mode_chg || div_chg) begin
                    ce_nxt    = 1'b0;
                    presc_nxt = '0;
                end else if (presc == presc_mask) begin
                    ce_nxt    = 1'b1;
                    presc_nxt = '0;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
        end
    end

    // Registered outputs, prescaler and pulse counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ce            <= 1'b0;
            periph_resetn <= 1'b0;
            core_resetn   <= 1'b0;
            halted        <= 1'b0;
            presc         <= '0;
            ce_count      <= '0;
        end else begin
            ce            <= ce_nxt;
            periph_resetn <= periph_nxt;
            core_resetn   <= core_nxt;
            halted        <= halted_nxt;
            presc         <= presc_nxt;
            // Leaving ACTIVE (lock loss) discards the count.
            if (nxt_state != ACTIVE) ce_count <= '0;
            else if (ce)             ce_count <= ce_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_clock_run_controller.sv
module tb_clock_run_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        pll_locked;
    logic [1:0]  mode;
    logic [4:0]  div_sel;
    logic        step_req;
    logic        halt_req;
    logic        ce;
    logic        periph_resetn;
    logic        core_resetn;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] ce_count;

    clock_run_controller #(
        .LOCK_FILTER(4), .PERIPH_DELAY(16), .CORE_DELAY(16), .DIV_W(5)
    ) dut (
        .CLK(CLK), .RESET(RESET), .pll_locked(pll_locked), .mode(mode),
        .div_sel(div_sel), .step_req(step_req), .halt_req(halt_req),
        .ce(ce), .periph_resetn(periph_resetn), .core_resetn(core_resetn),
        .halted(halted), .state(state), .ce_count(ce_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    int sb_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},  {30'd0, state}, 32'd0);
        chk({tag, "_ce"},     {31'd0, ce}, 32'd0);
        chk({tag, "_presetn"},{31'd0, periph_resetn}, 32'd0);
        chk({tag, "_cresetn"},{31'd0, core_resetn}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_cecount"}, ce_count, 32'd0);
    endtask

    // Scoreboard: every ce pulse seen while enabled must match the head of
    // the queue of expected pulse cycles.
    always @(negedge CLK) begin
        if (mon_en && ce) begin
            if (sb_q.size() == 0) begin
                chk("ce_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                chk("ce_pulse_cycle", 32'(cyc), 32'(sb_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic       lock;
        int         adv;
        logic [1:0] st;
        logic       pr;
        logic       cr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Reset sequence, including a one-cycle lock drop in CORE_RST.
        tbl[0]  = '{1'b1, 0,  2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3,  2'b00, 1'b0, 1'b0};  // edge 3
        tbl[2]  = '{1'b1, 1,  2'b01, 1'b0, 1'b0};  // edge 4
        tbl[3]  = '{1'b1, 15, 2'b01, 1'b0, 1'b0};  // edge 19
        tbl[4]  = '{1'b1, 1,  2'b10, 1'b1, 1'b0};  // edge 20
        tbl[5]  = '{1'b1, 5,  2'b10, 1'b1, 1'b0};  // edge 25
        tbl[6]  = '{1'b0, 1,  2'b00, 1'b0, 1'b0};  // edge 26, lock dropped
        tbl[7]  = '{1'b1, 3,  2'b00, 1'b0, 1'b0};  // edge 29
        tbl[8]  = '{1'b1, 1,  2'b01, 1'b0, 1'b0};  // edge 30
        tbl[9]  = '{1'b1, 16, 2'b10, 1'b1, 1'b0};  // edge 46
        tbl[10] = '{1'b1, 15, 2'b10, 1'b1, 1'b0};  // edge 61
        tbl[11] = '{1'b1, 1,  2'b11, 1'b1, 1'b1};  // edge 62

        RESET = 1'b1; pll_locked = 1'b1; mode = 2'b00; div_sel = 5'd0;
        step_req = 1'b0; halt_req = 1'b0;
        tick(3);
        chk_reset_vals("rst");
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 12; i++) begin
            pll_locked = tbl[i].lock;
            tick(tbl[i].adv);
            chk($sformatf("seq%0d_state", i), {30'd0, state}, {30'd0, tbl[i].st});
            chk($sformatf("seq%0d_presetn", i), {31'd0, periph_resetn}, {31'd0, tbl[i].pr});
            chk($sformatf("seq%0d_cresetn", i), {31'd0, core_resetn}, {31'd0, tbl[i].cr});
        end
        chk("active_halt_ce", {31'd0, ce}, 32'd0);

        // RUN, then halt on the instruction at ce_count=10.
        mode = 2'b01;
        tick(1);
        chk("run_ce_first", {31'd0, ce}, 32'd1);
        chk("run_cnt_first", ce_count, 32'd0);
        tick(10);
        chk("run_cnt_10", ce_count, 32'd10);
        halt_req = 1'b1;
        tick(1);
        chk("halt_set", {31'd0, halted}, 32'd1);
        chk("halt_ce", {31'd0, ce}, 32'd0);
        chk("halt_cnt", ce_count, 32'd11);
        tick(5);
        chk("halt_hold_ce", {31'd0, ce}, 32'd0);
        chk("halt_hold_cnt", ce_count, 32'd11);
        halt_req = 1'b0;
        mode = 2'b00;
        tick(1);
        chk("halt_clr_mode", {31'd0, halted}, 32'd0);

        // STEP: two long button presses, one pulse each, 3 edges after rise.
        mon_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step_req = 1'b1;
            sb_q.push_back(cyc + 3);
            tick(50);
            step_req = 1'b0;
            tick(10);
        end
        mon_en = 1'b0;
        chk("step_q_empty", 32'(sb_q.size()), 32'd0);
        chk("step_cnt", ce_count, 32'd13);

        // Steps in RUN leave ce untouched.
        mode = 2'b01;
        tick(1);
        step_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("run_step_ce", {31'd0, ce}, 32'd1);
        end
        step_req = 1'b0;

        // SLOW div 3: change clears prescaler, then one pulse every 8 cycles.
        mode = 2'b10; div_sel = 5'd3;
        tick(1);
        chk("slow3_clr_ce", {31'd0, ce}, 32'd0);
        mon_en = 1'b1;
        sb_q.push_back(cyc + 8);
        sb_q.push_back(cyc + 16);
        sb_q.push_back(cyc + 24);
        tick(29);
        mon_en = 1'b0;
        chk("slow3_q_empty", 32'(sb_q.size()), 32'd0);

        // div 0 behaves as RUN.
        div_sel = 5'd0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("slow0_ce", {31'd0, ce}, 32'd1);
        end

        // div 2: first pulse a full 4-cycle period after the clearing edge.
        div_sel = 5'd2;
        tick(1);
        chk("slow2_clr_ce", {31'd0, ce}, 32'd0);
        mon_en = 1'b1;
        sb_q.push_back(cyc + 4);
        sb_q.push_back(cyc + 8);
        tick(10);
        mon_en = 1'b0;
        chk("slow2_q_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset between edges.
        #2;
        RESET = 1'b1;
        #1;
        chk_reset_vals("async");

        // Restart in RUN, halt, then lose lock in ACTIVE.
        repeat (2) @(negedge CLK);
        pll_locked = 1'b1; mode = 2'b01; div_sel = 5'd0;
        RESET = 1'b0;
        tick(36);
        chk("re_state", {30'd0, state}, 32'd3);
        chk("re_cresetn", {31'd0, core_resetn}, 32'd1);
        tick(3);
        halt_req = 1'b1;
        tick(2);
        chk("re_halted", {31'd0, halted}, 32'd1);
        chk("re_cnt", ce_count, 32'd3);
        halt_req = 1'b0;
        pll_locked = 1'b0;
        tick(1);
        chk_reset_vals("lockloss");
        pll_locked = 1'b1;
        tick(20);
        chk("relock_state", {30'd0, state}, 32'd2);
        chk("relock_presetn", {31'd0, periph_resetn}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
